// File: rtl/ha_array_seq_reducer.sv
// Serial final-addition stage for the approximate 8x8 multiplier: folds the four
// half-adder rows into a 16-bit product through one shared adder, one row per clock.
module ha_array_seq_reducer #(
    parameter int SAT_EN = 1,
    parameter int ACC_W  = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] ha_array_0_t,
    input  logic [6:0] ha_array_0_b,
    input  logic [8:0] ha_array_1_t,
    input  logic [6:0] ha_array_1_b,
    input  logic [8:0] ha_array_2_t,
    input  logic [6:0] ha_array_2_b,
    input  logic [8:0] ha_array_3_t,
    input  logic [6:0] ha_array_3_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [15:0] product,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [8:0]       t_q [4];
    logic [6:0]       b_q [4];
    logic [1:0]       row_cnt;
    logic [ACC_W-1:0] acc;
    logic [9:0]       row_val;
    logic [ACC_W-1:0] row_term;
    logic             accept;
    logic             acc_over;

    assign accept = in_valid && in_ready;

    // Shared adder input: the row selected by row_cnt, weighted by 4^row_cnt.
    always_comb begin
        row_val  = {1'b0, t_q[row_cnt]} + {1'b0, b_q[row_cnt], 2'b00};
        row_term = ACC_W'(row_val) << {row_cnt, 1'b0};
    end

    assign acc_over = (acc > ACC_W'(16'hFFFF));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        product   = '0;
        overflow  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                if (row_cnt == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                overflow  = acc_over;
                product   = ((SAT_EN != 0) && acc_over) ? 16'hFFFF : acc[15:0];
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            row_cnt <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                t_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (accept) begin
            acc     <= '0;
            row_cnt <= '0;
            t_q[0]  <= ha_array_0_t;
            b_q[0]  <= ha_array_0_b;
            t_q[1]  <= ha_array_1_t;
            b_q[1]  <= ha_array_1_b;
            t_q[2]  <= ha_array_2_t;
            b_q[2]  <= ha_array_2_b;
            t_q[3]  <= ha_array_3_t;
            b_q[3]  <= ha_array_3_b;
        end else if (state == ACC) begin
            acc     <= acc + row_term;
            row_cnt <= row_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_ha_array_seq_reducer.sv
// Directed self-checking bench for ha_array_seq_reducer; a saturating and a
// truncating instance share the same stimulus.
module tb_ha_array_seq_reducer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [8:0]  t [4];
    logic [6:0]  b [4];
    logic        in_ready, out_valid, overflow;
    logic [15:0] product;
    logic        in_ready_tr, out_valid_tr, overflow_tr;
    logic [15:0] product_tr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept;
    int unsigned exp_sum;
    logic [15:0] held_product;

    ha_array_seq_reducer #(.SAT_EN(1), .ACC_W(17)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ha_array_0_t(t[0]), .ha_array_0_b(b[0]),
        .ha_array_1_t(t[1]), .ha_array_1_b(b[1]),
        .ha_array_2_t(t[2]), .ha_array_2_b(b[2]),
        .ha_array_3_t(t[3]), .ha_array_3_b(b[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .overflow(overflow)
    );

    ha_array_seq_reducer #(.SAT_EN(0), .ACC_W(17)) dut_tr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_tr),
        .ha_array_0_t(t[0]), .ha_array_0_b(b[0]),
        .ha_array_1_t(t[1]), .ha_array_1_b(b[1]),
        .ha_array_2_t(t[2]), .ha_array_2_b(b[2]),
        .ha_array_3_t(t[3]), .ha_array_3_b(b[3]),
        .out_valid(out_valid_tr), .out_ready(out_ready),
        .product(product_tr), .overflow(overflow_tr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned ref_sum();
        int unsigned s = 0;
        for (int k = 0; k < 4; k++) begin
            s += (int'(t[k]) + (int'(b[k]) << 2)) << (2 * k);
        end
        return s;
    endfunction

    task automatic set_rows(input logic [8:0] t0, t1, t2, t3, input logic [6:0] b0, b1, b2, b3);
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    endtask

    task automatic start(input string tag);
        chk({tag, " in_ready idle"}, in_ready, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, " in_ready acc"}, in_ready, 0);
    endtask

    // Three ACC edges with out_valid low, then DONE after the fourth.
    task automatic wait_done(input string tag);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, " out_valid early"}, out_valid, 0);
        end
        tick();
        chk({tag, " out_valid"}, out_valid, 1);
    endtask

    task automatic check_out(input string tag, input int unsigned s);
        chk({tag, " product sat"}, product, (s > 32'hFFFF) ? 32'hFFFF : (s & 32'hFFFF));
        chk({tag, " overflow sat"}, overflow, (s > 32'hFFFF) ? 1 : 0);
        chk({tag, " product trunc"}, product_tr, s & 32'hFFFF);
        chk({tag, " overflow trunc"}, overflow_tr, (s > 32'hFFFF) ? 1 : 0);
    endtask

    task automatic release_out(input string tag);
        tick();
        chk({tag, " out_valid low"}, out_valid, 0);
        chk({tag, " in_ready back"}, in_ready, 1);
    endtask

    task automatic run(input string tag, input int unsigned s);
        start(tag);
        wait_done(tag);
        check_out(tag, s);
        release_out(tag);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_rows(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset product", product, 0);
        chk("reset overflow", overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        run("zero", 0);

        set_rows(1, 0, 0, 0, 0, 0, 0, 0);
        run("t0bit0", 1);
        set_rows(0, 0, 0, 0, 0, 0, 0, 7'h40);
        run("b3bit6", 16384);

        set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        chk("allones model", ref_sum(), 86615);
        start("allones");
        wait_done("allones");
        chk("allones sat", product, 16'hFFFF);
        chk("allones sat ovf", overflow, 1);
        chk("allones trunc", product_tr, 21079);
        chk("allones trunc ovf", overflow_tr, 1);
        release_out("allones");

        // Backpressure: R1 = 100<<2 = 400, R2 = 12<<4 = 192, total 592.
        set_rows(0, 100, 0, 0, 0, 0, 3, 0);
        out_ready = 1'b0;
        start("bp");
        wait_done("bp");
        chk("bp product", product, 592);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_rows(9'h1FF, 9'h1FF, 0, 0, 7'h7F, 0, 0, 0);
            tick();
            chk("bp hold valid", out_valid, 1);
            chk("bp hold product", product, 592);
            chk("bp hold overflow", overflow, 0);
            chk("bp hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp released valid", out_valid, 0);
        chk("bp released in_ready", in_ready, 1);

        // Abort in ACC once two rows have been added (row_cnt == 2).
        set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        start("abort");
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort in_ready", in_ready, 1);
        chk("abort out_valid", out_valid, 0);
        chk("abort product", product, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort no output", out_valid, 0);
        end
        set_rows(5, 6, 7, 8, 1, 2, 3, 4);
        exp_sum = ref_sum();
        chk("post abort model", exp_sum, 9 + (14 << 2) + (19 << 4) + (24 << 6));
        run("post abort", exp_sum);

        // Back-to-back random transactions; inputs scrambled right after each accept.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t[i] = 9'($urandom);
            b[i] = 7'($urandom);
        end
        for (int n = 0; n < 5; n++) begin
            for (int w = 0; w < 10 && !in_ready; w++) tick();
            chk("rand in_ready", in_ready, 1);
            exp_sum = ref_sum();
            tick();
            if (n > 0) chk("rand spacing", cyc - last_accept, 6);
            last_accept = cyc;
            for (int i = 0; i < 4; i++) begin
                t[i] = 9'($urandom);
                b[i] = 7'($urandom);
            end
            wait_done("rand");
            check_out("rand", exp_sum);
            held_product = product;
            tick();
        end
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
